// File: rtl/gpio_write_arbiter.sv
// Round-robin arbiter sharing the GPIO output register's write port between
// the CPU store path (requester 0) and the peripheral sequencer (requester 1).
module gpio_write_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  input  logic [WIDTH-1:0] gpio_q,
  output logic [WIDTH-1:0] gpio_d,
  output logic             gpio_en,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_e;
  typedef enum logic [1:0] {OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE} op_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             gpio_en_q, gpio_en_d;
  logic             busy_q, busy_d;
  logic             winner;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    last_d    = last_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    gpio_en_d = 1'b0;
    busy_d    = busy_q;
    // On a tie the requester that was not served last wins.
    winner    = (req0 && req1) ? ~last_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = GRANT;
          op_d    = winner ? op1 : op0;
          data_d  = winner ? data1 : data0;
          last_d  = winner;
          ack0_d  = ~winner;
          ack1_d  = winner;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        state_d   = WRITE;
        gpio_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      WRITE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      data_q    <= '0;
      last_q    <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      gpio_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      last_q    <= last_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      gpio_en_q <= gpio_en_d;
      busy_q    <= busy_d;
    end
  end

  // Read-modify-write against the live register output, only while writing.
  always_comb begin
    gpio_d = '0;
    if (state_q == WRITE) begin
      case (op_e'(op_q))
        OP_WRITE:  gpio_d = data_q;
        OP_SET:    gpio_d = gpio_q | data_q;
        OP_CLEAR:  gpio_d = gpio_q & ~data_q;
        OP_TOGGLE: gpio_d = gpio_q ^ data_q;
        default:   gpio_d = '0;
      endcase
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign gpio_en = gpio_en_q;
  assign busy    = busy_q;

endmodule
